// File: rtl/button_pkg.sv
// Shared types for the button press classifier.
// Holds the FSM state enum and the counter width helper.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG,
    GAP,
    PRESS2
  } press_state_t;

  // Bits needed to hold the larger of two limits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: i_Clk, i_Rst_L (sync, active low), i_Clr, i_Inc, o_Count.
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Clr,
  input  logic             i_Inc,
  output logic [WIDTH-1:0] o_Count
);

  logic [WIDTH-1:0] r_Count;
  logic [WIDTH-1:0] w_Base;

  // Clear and increment together load 1.
  always_comb begin
    w_Base = i_Clr ? '0 : r_Count;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L)
      r_Count <= '0;
    else if (i_Inc && (w_Base != '1))
      r_Count <= w_Base + WIDTH'(1'b1);
    else
      r_Count <= w_Base;
  end

  assign o_Count = r_Count;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies a debounced button into short/long/double press pulses.
// Ports: i_Clk, i_Rst_L, i_Debounced -> o_Short_Press, o_Long_Press,
//        o_Double_Press (1-cycle pulses), o_Held (long press level).
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_LIMIT       = 250000,
  parameter int DOUBLE_GAP_LIMIT = 100000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Debounced,
  output logic o_Short_Press,
  output logic o_Long_Press,
  output logic o_Double_Press,
  output logic o_Held
);

  localparam int CW = cnt_width(LONG_LIMIT, DOUBLE_GAP_LIMIT);

  press_state_t r_State;
  press_state_t w_Next;
  logic [CW-1:0] w_Cnt;
  logic r_Prev;
  logic r_Short, r_Long, r_Double, r_Held;
  logic w_Short, w_Long, w_Double;
  logic w_Clr, w_Inc;
  logic w_Rise, w_Long_Hit, w_Gap_Hit;

  sat_counter #(.WIDTH(CW)) u_cnt (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Clr   (w_Clr),
    .i_Inc   (w_Inc),
    .o_Count (w_Cnt)
  );

  // Decisions fire on the sample that would make the count hit the limit.
  assign w_Rise     = i_Debounced && !r_Prev;
  assign w_Long_Hit = (w_Cnt == CW'(LONG_LIMIT - 1));
  assign w_Gap_Hit  = (w_Cnt == CW'(DOUBLE_GAP_LIMIT - 1));

  always_comb begin
    w_Next   = r_State;
    w_Short  = 1'b0;
    w_Long   = 1'b0;
    w_Double = 1'b0;
    w_Clr    = 1'b0;
    w_Inc    = 1'b0;
    case (r_State)
      IDLE: begin
        w_Clr = 1'b1;
        if (w_Rise) begin
          w_Next = PRESS1;
          w_Inc  = 1'b1;
        end
      end
      PRESS1, PRESS2: begin
        if (i_Debounced) begin
          if (w_Long_Hit) begin
            w_Next = LONG;
            w_Long = 1'b1;
            w_Clr  = 1'b1;
          end else begin
            w_Inc = 1'b1;
          end
        end else if (r_State == PRESS1) begin
          w_Next = GAP;
          w_Clr  = 1'b1;
          w_Inc  = 1'b1;
        end else begin
          w_Next   = IDLE;
          w_Double = 1'b1;
          w_Clr    = 1'b1;
        end
      end
      LONG: begin
        w_Clr = 1'b1;
        if (!i_Debounced)
          w_Next = IDLE;
      end
      GAP: begin
        if (i_Debounced) begin
          w_Next = PRESS2;
          w_Clr  = 1'b1;
          w_Inc  = 1'b1;
        end else if (w_Gap_Hit) begin
          w_Next  = IDLE;
          w_Short = 1'b1;
          w_Clr   = 1'b1;
        end else begin
          w_Inc = 1'b1;
        end
      end
      default: begin
        w_Next = IDLE;
        w_Clr  = 1'b1;
      end
    endcase
  end

  // r_Prev resets high so a button held through reset is ignored.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State  <= IDLE;
      r_Prev   <= 1'b1;
      r_Short  <= 1'b0;
      r_Long   <= 1'b0;
      r_Double <= 1'b0;
      r_Held   <= 1'b0;
    end else begin
      r_State  <= w_Next;
      r_Prev   <= i_Debounced;
      r_Short  <= w_Short;
      r_Long   <= w_Long;
      r_Double <= w_Double;
      r_Held   <= (w_Next == LONG);
    end
  end

  assign o_Short_Press  = r_Short;
  assign o_Long_Press   = r_Long;
  assign o_Double_Press = r_Double;
  assign o_Held         = r_Held;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: directed scenarios plus random
// press/release runs checked cycle by cycle against a run-length model.
module tb_button_press_classifier;

  localparam int LONG_LIMIT       = 8;
  localparam int DOUBLE_GAP_LIMIT = 5;

  logic i_Clk = 1'b0;
  logic i_Rst_L = 1'b0;
  logic i_Debounced = 1'b0;
  logic o_Short_Press, o_Long_Press, o_Double_Press, o_Held;

  int n_vec = 0;
  int n_bad = 0;

  // Model: run lengths and press context, not states.
  bit m_prev = 1'b1;
  bit m_held = 1'b0;
  bit m_wait = 1'b0;
  bit m_second = 1'b0;
  int m_hi = 0;
  int m_lo = 0;

  button_press_classifier #(
    .LONG_LIMIT       (LONG_LIMIT),
    .DOUBLE_GAP_LIMIT (DOUBLE_GAP_LIMIT)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Debounced    (i_Debounced),
    .o_Short_Press  (o_Short_Press),
    .o_Long_Press   (o_Long_Press),
    .o_Double_Press (o_Double_Press),
    .o_Held         (o_Held)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got {S,L,D,H}=%b want %b",
               tag, $time, got, exp);
    end
  endtask

  // Apply one sample, advance one clock, compare all outputs.
  task automatic step(input string tag, input bit rst_n, input bit v);
    logic [3:0] exp;
    bit s, l, d;
    i_Rst_L = rst_n;
    i_Debounced = v;
    @(posedge i_Clk);
    #1;
    s = 0; l = 0; d = 0;
    if (!rst_n) begin
      m_prev = 1; m_held = 0; m_wait = 0;
      m_second = 0; m_hi = 0; m_lo = 0;
    end else begin
      if (v) begin
        if (m_held) begin
        end else if (m_hi > 0) begin
          m_hi++;
          if (m_hi == LONG_LIMIT) begin
            l = 1; m_held = 1; m_hi = 0; m_second = 0;
          end
        end else if (m_wait) begin
          m_wait = 0; m_second = 1; m_hi = 1;
        end else if (!m_prev) begin
          m_hi = 1; m_second = 0;
        end
      end else begin
        if (m_held) begin
          m_held = 0;
        end else if (m_hi > 0) begin
          if (m_second) d = 1;
          else begin
            m_wait = 1; m_lo = 1;
          end
          m_hi = 0; m_second = 0;
        end else if (m_wait) begin
          m_lo++;
          if (m_lo == DOUBLE_GAP_LIMIT) begin
            s = 1; m_wait = 0;
          end
        end
      end
      m_prev = v;
    end
    exp = {s, l, d, m_held};
    chk(tag, {o_Short_Press, o_Long_Press, o_Double_Press, o_Held}, exp);
  endtask

  task automatic run(input string tag, input bit v, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, v);
  endtask

  initial begin
    // 1: held through reset is ignored, then a short press
    step("t1_rst", 1'b0, 1'b1);
    step("t1_rst", 1'b0, 1'b1);
    run("t1_held", 1'b1, 10);
    run("t1_lo", 1'b0, 1);
    run("t1_hi", 1'b1, 3);
    run("t1_gap", 1'b0, 6);
    // 2: short press
    run("t2_hi", 1'b1, 3);
    run("t2_gap", 1'b0, 7);
    // 3: long press and held level
    run("t3_hi", 1'b1, 11);
    run("t3_lo", 1'b0, 3);
    // 4: double press
    run("t4", 1'b1, 2);
    run("t4", 1'b0, 4);
    run("t4", 1'b1, 2);
    run("t4", 1'b0, 7);
    // 5: gap reaches limit twice, two shorts
    run("t5", 1'b1, 2);
    run("t5", 1'b0, 5);
    run("t5", 1'b1, 2);
    run("t5", 1'b0, 6);
    // 6: reset mid-gap drops the pending press
    run("t6", 1'b1, 2);
    run("t6", 1'b0, 2);
    step("t6_rst", 1'b0, 1'b0);
    run("t6_lo", 1'b0, 10);
    // second press turning long
    run("t7", 1'b1, 2);
    run("t7", 1'b0, 3);
    run("t7", 1'b1, 9);
    run("t7", 1'b0, 6);
    // random runs with occasional reset
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0)
        step("rnd_rst", 1'b0, 1'($urandom_range(0, 1)));
      run("rnd_hi", 1'b1, $urandom_range(1, 10));
      run("rnd_lo", 1'b0, $urandom_range(1, 7));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
